// File: rtl/pong_pkg.sv
// Shared game-state encoding and default playfield geometry for the pong blocks.
package pong_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SERVE = 2'd1,
    PLAY  = 2'd2,
    PAUSE = 2'd3
  } game_state_t;

  localparam int FIELD_H_DEF  = 480;
  localparam int PADDLE_H_DEF = 64;
  localparam int STEP_DEF     = 8;
  localparam int MAX_PEND_DEF = 7;

endpackage

// File: rtl/button_debounce.sv
// Two-flop synchroniser plus stability-count debouncer; pulses press on each accepted 0->1.
module button_debounce #(
  parameter int DEB_CYCLES = 250000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic btn,
  output logic press
);

  localparam int CNT_W = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEB_CYCLES - 1);

  logic [1:0]       sync;
  logic             level;
  logic [CNT_W-1:0] cnt;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sync  <= '0;
      level <= 1'b0;
      cnt   <= '0;
      press <= 1'b0;
    end else begin
      sync  <= {sync[0], btn};
      press <= 1'b0;
      // Any cycle agreeing with the accepted level restarts the stability window.
      if (sync[1] != level) begin
        if (cnt == CNT_LAST) begin
          level <= sync[1];
          press <= sync[1];
          cnt   <= '0;
        end else begin
          cnt <= cnt + CNT_W'(1);
        end
      end else begin
        cnt <= '0;
      end
    end
  end

endmodule

// File: rtl/paddle_controller.sv
// Pong paddle positioning from encoder detents plus the serve/play/pause game FSM.
module paddle_controller
  import pong_pkg::*;
#(
  parameter int FIELD_H    = FIELD_H_DEF,
  parameter int PADDLE_H   = PADDLE_H_DEF,
  parameter int STEP       = STEP_DEF,
  parameter int MAX_PEND   = MAX_PEND_DEF,
  parameter int DEB_CYCLES = 250000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       p1_up,
  input  logic       p1_down,
  input  logic       p2_up,
  input  logic       p2_down,
  input  logic       p1_button,
  input  logic       p2_button,
  input  logic       frame_tick,
  input  logic       point_scored,
  output logic [9:0] p1_y,
  output logic [9:0] p2_y,
  output logic [1:0] state,
  output logic       server,
  output logic       serve_start
);

  localparam int NUM_P = 2;
  localparam int YMAX  = FIELD_H - PADDLE_H;
  localparam int CW    = $clog2(MAX_PEND + 1) + 1;
  localparam logic [9:0]          CENTRE = 10'(YMAX / 2);
  localparam logic signed [CW:0]  PMAX   = (CW+1)'(MAX_PEND);
  localparam logic signed [CW:0]  PMIN   = -PMAX;
  localparam logic signed [11:0]  YMAX_S = 12'(YMAX);
  localparam logic signed [11:0]  STEP_S = 12'(STEP);

  game_state_t                 st;
  logic [NUM_P-1:0]            up, dn, btn, press;
  logic [NUM_P-1:0][9:0]       y;
  logic [NUM_P-1:0][CW-1:0]    cnt;
  logic signed [1:0]           dlt  [NUM_P];
  logic signed [CW:0]          sum  [NUM_P];
  logic [CW-1:0]               sat  [NUM_P];
  logic signed [11:0]          ny   [NUM_P];
  logic [9:0]                  nyc  [NUM_P];
  logic                        active, any_press;

  assign up  = {p2_up, p1_up};
  assign dn  = {p2_down, p1_down};
  assign btn = {p2_button, p1_button};

  for (genvar i = 0; i < NUM_P; i++) begin : g_deb
    button_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb (
      .clk   (clk),
      .rst_n (rst_n),
      .btn   (btn[i]),
      .press (press[i])
    );
  end

  assign any_press = |press;
  assign active    = (st == SERVE) || (st == PLAY);

  always_comb begin
    for (int i = 0; i < NUM_P; i++) begin
      dlt[i] = (up[i] & ~dn[i]) ? 2'sb01 : (dn[i] & ~up[i]) ? 2'sb11 : 2'sb00;
      sum[i] = $signed({cnt[i][CW-1], cnt[i]}) + (CW+1)'(dlt[i]);
      sat[i] = (sum[i] > PMAX) ? PMAX[CW-1:0] :
               (sum[i] < PMIN) ? PMIN[CW-1:0] : sum[i][CW-1:0];
      // Widened signed math so the clamp sees true under/overshoot, never a wrap.
      ny[i]  = $signed({2'b00, y[i]}) - 12'($signed(cnt[i])) * STEP_S;
      nyc[i] = (ny[i] < 0)      ? 10'd0 :
               (ny[i] > YMAX_S) ? YMAX_S[9:0] : ny[i][9:0];
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      st          <= IDLE;
      server      <= 1'b0;
      serve_start <= 1'b0;
      y           <= {NUM_P{CENTRE}};
      cnt         <= '0;
    end else begin
      serve_start <= 1'b0;
      // A tick reloads the count with this cycle's own detent so none is dropped.
      for (int i = 0; i < NUM_P; i++) begin
        if (active) begin
          if (frame_tick) begin
            y[i]   <= nyc[i];
            cnt[i] <= CW'(dlt[i]);
          end else begin
            cnt[i] <= sat[i];
          end
        end else begin
          cnt[i] <= '0;
        end
      end
      case (st)
        IDLE: if (any_press) begin
          st <= SERVE;
          y  <= {NUM_P{CENTRE}};
        end
        SERVE: if (press[server]) begin
          st          <= PLAY;
          serve_start <= 1'b1;
        end
        PLAY: begin
          if (point_scored) begin
            st     <= SERVE;
            server <= ~server;
          end else if (any_press) begin
            st <= PAUSE;
          end
        end
        PAUSE: if (any_press) st <= PLAY;
        default: st <= IDLE;
      endcase
    end
  end

  assign state = st;
  assign p1_y  = y[0];
  assign p2_y  = y[1];

endmodule

// File: tb/tb_paddle_controller.sv
// Directed bench for paddle_controller with a short debounce window.
module tb_paddle_controller;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       p1_up = 0, p1_down = 0, p2_up = 0, p2_down = 0;
  logic       p1_button = 0, p2_button = 0;
  logic       frame_tick = 0, point_scored = 0;
  logic [9:0] p1_y, p2_y;
  logic [1:0] state;
  logic       server, serve_start;

  int tests = 0, fails = 0;
  int n_press = 0, n_ss = 0, ss_run = 0, ss_maxw = 0;
  int snap;

  paddle_controller #(.DEB_CYCLES(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .p1_up(p1_up), .p1_down(p1_down), .p2_up(p2_up), .p2_down(p2_down),
    .p1_button(p1_button), .p2_button(p2_button),
    .frame_tick(frame_tick), .point_scored(point_scored),
    .p1_y(p1_y), .p2_y(p2_y), .state(state), .server(server),
    .serve_start(serve_start)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    n_press += int'(dut.press[0]) + int'(dut.press[1]);
    if (serve_start) begin
      if (ss_run == 0) n_ss++;
      ss_run++;
      if (ss_run > ss_maxw) ss_maxw = ss_run;
    end else begin
      ss_run = 0;
    end
  end

  task automatic chk(input string tag, input int obs, input int exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic frame();
    frame_tick = 1; tick(); frame_tick = 0;
  endtask

  task automatic detents(input int pl, input int n, input bit upd);
    repeat (n) begin
      if (pl == 0) begin p1_up = upd; p1_down = !upd; end
      else         begin p2_up = upd; p2_down = !upd; end
      tick();
      p1_up = 0; p1_down = 0; p2_up = 0; p2_down = 0;
    end
  endtask

  task automatic move(input int pl, input int n, input bit upd);
    detents(pl, n, upd);
    frame();
  endtask

  task automatic press_btn(input int pl);
    if (pl == 0) p1_button = 1; else p2_button = 1;
    repeat (8) tick();
    p1_button = 0; p2_button = 0;
    repeat (8) tick();
  endtask

  initial begin
    repeat (2) tick();
    chk("rst_state", state, 0);
    chk("rst_server", server, 0);
    chk("rst_serve_start", serve_start, 0);
    chk("rst_p1_y", p1_y, 208);
    chk("rst_p2_y", p2_y, 208);
    rst_n = 1;
    tick();

    // exactly six cycles of held button
    p1_button = 1; repeat (6) tick(); p1_button = 0; repeat (10) tick();
    chk("hold6_press_count", n_press, 1);
    chk("idle_to_serve", state, 1);
    chk("serve_p1_y", p1_y, 208);
    chk("serve_p2_y", p2_y, 208);

    press_btn(0);
    chk("serve_to_play", state, 2);
    chk("first_serve_start", n_ss, 1);

    move(0, 3, 1);
    chk("p1_up3", p1_y, 184);
    move(1, 10, 0);
    chk("p2_down_sat", p2_y, 264);
    chk("p1_unmoved", p1_y, 184);

    move(0, 7, 1); move(0, 7, 1); move(0, 7, 1); move(0, 1, 1);
    chk("p1_at_8", p1_y, 8);
    move(0, 2, 1);
    chk("p1_clamp_0", p1_y, 0);
    move(1, 7, 0); move(1, 7, 0); move(1, 5, 0);
    chk("p2_at_416", p2_y, 416);
    move(1, 1, 0);
    chk("p2_clamp_max", p2_y, 416);

    move(0, 2, 0);
    chk("p1_at_16", p1_y, 16);
    detents(0, 1, 0);
    p1_up = 1; frame_tick = 1; tick(); p1_up = 0; frame_tick = 0;
    chk("coincident_tick_old_count", p1_y, 24);
    frame();
    chk("coincident_new_count", p1_y, 16);

    detents(1, 1, 1);
    repeat (3) begin p2_up = 1; p2_down = 1; tick(); p2_up = 0; p2_down = 0; end
    frame();
    chk("both_pulses_cancel", p2_y, 408);

    press_btn(1);
    chk("play_to_pause", state, 3);
    move(0, 3, 1);
    chk("pause_discards", p1_y, 16);
    press_btn(0);
    chk("pause_to_play", state, 2);
    chk("resume_no_serve_start", n_ss, 1);
    frame();
    chk("pause_count_held_zero", p1_y, 16);

    // press pulse and point_scored land in the same FSM cycle
    p2_button = 1; repeat (6) tick();
    point_scored = 1; tick(); point_scored = 0;
    repeat (1) tick(); p2_button = 0; repeat (8) tick();
    chk("point_wins_state", state, 1);
    chk("point_server", server, 1);
    chk("point_keep_p1", p1_y, 16);
    chk("point_keep_p2", p2_y, 408);
    point_scored = 1; tick(); point_scored = 0; tick();
    chk("point_ignored_serve", server, 1);
    press_btn(0);
    chk("other_player_ignored", state, 1);
    press_btn(1);
    chk("p2_serves", state, 2);
    chk("serve_start_count", n_ss, 2);
    chk("serve_start_width", ss_maxw, 1);

    snap = n_press;
    p1_button = 1; repeat (2) tick(); p1_button = 0; repeat (10) tick();
    chk("glitch_no_press", n_press, snap);
    chk("glitch_state", state, 2);

    press_btn(1);
    chk("pause_again", state, 3);
    rst_n = 0; tick();
    chk("reset_pause_state", state, 0);
    chk("reset_p1_y", p1_y, 208);
    chk("reset_p2_y", p2_y, 208);
    chk("reset_server", server, 0);
    snap = n_press;
    rst_n = 1; repeat (10) tick();
    chk("no_press_after_reset", n_press, snap);
    chk("idle_after_reset", state, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/paddle_controller.md
PADDLE_CONTROLLER -- requirements
Module: paddle_controller

Interface
REQ-001 SHALL have parameter FIELD_H, 480, playfield height in pixels.
REQ-002 SHALL have parameter PADDLE_H, 64, paddle height in pixels.
REQ-003 SHALL have parameter STEP, 8, pixels moved per encoder detent.
REQ-004 SHALL have parameter MAX_PEND, 7, saturation bound of the pending-detent count.
REQ-005 SHALL have parameter DEB_CYCLES, 250000, cycles a button level must be stable before it is accepted.
REQ-006 SHALL have clk  input  1  system clock; one clock, all logic on the rising edge.
REQ-007 SHALL have rst_n  input  1  reset; synchronous, active-low.
REQ-008 SHALL have p1_up, p1_down, p2_up, p2_down  input  1 each  single-cycle detent pulses from the encoder decoders.
REQ-009 SHALL have p1_button, p2_button  input  1 each  raw asynchronous push-switch level, 1 = pressed.
REQ-010 SHALL have frame_tick  input  1  one-cycle pulse per video frame.
REQ-011 SHALL have point_scored  input  1  one-cycle pulse from the ball logic.
REQ-012 SHALL have p1_y, p2_y  output  10 each  paddle top-edge row.
REQ-013 SHALL have state  output  2  game state: IDLE=0, SERVE=1, PLAY=2, PAUSE=3.
REQ-014 SHALL have server  output  1  serving player: 0 = p1, 1 = p2.
REQ-015 SHALL have serve_start  output  1  one-cycle pulse on SERVE->PLAY.

Function
REQ-016 SHALL keep one signed pending count per player, range -MAX_PEND..+MAX_PEND.
REQ-017 SHALL increment the count on up, decrement it on down, leave it unchanged when both pulse in the same cycle, and saturate at either bound.
REQ-018 SHALL, on frame_tick in SERVE or PLAY, set y = clamp(y - count*STEP, 0, FIELD_H-PADDLE_H); a positive count moves the paddle up (smaller y).
REQ-019 SHALL, on frame_tick, load the count with that cycle's own up/down delta (0 or ±1) rather than clear it, so no pulse is lost.
REQ-020 SHALL perform the clamp arithmetic in at least 12-bit signed width; no wrap-around at 0 or at the maximum.
REQ-021 SHALL, in IDLE and PAUSE, discard detent pulses and hold the count at 0.
REQ-022 SHALL pass each button through a 2-FF synchroniser, then a debouncer.
REQ-023 The debouncer SHALL change its debounced level only after DEB_CYCLES consecutive cycles with the synchronised input differing from that level.
REQ-024 The debouncer SHALL emit a one-cycle press pulse on each debounced 0->1 transition.
REQ-025 SHALL treat a press from either player as "any press"; simultaneous presses count as one.
REQ-026 State machine transitions:
  - IDLE: any press -> SERVE, centre both paddles.
  - SERVE: press by the player selected by server -> PLAY, serve_start=1 for one cycle; presses by the other player ignored.
  - PLAY: point_scored -> SERVE, server toggles, paddles keep position.
  - PLAY: otherwise any press -> PAUSE; point_scored wins if both occur in one cycle.
  - PAUSE: any press -> PLAY, no serve_start.
REQ-027 SHALL ignore point_scored outside PLAY.
REQ-028 SHALL define centre as (FIELD_H-PADDLE_H)/2, which is 208 at the defaults.

Reset
REQ-029 SHALL, while rst_n=0 at a clock edge, set: state=IDLE; server=0; serve_start=0; p1_y=p2_y=208; pending counts=0; synchronisers, debounce counters and debounced levels=0.
REQ-030 SHALL abandon any debounce, pending move or state mid-operation on reset, with no press pulse generated at reset release.

Structure
REQ-031 SHALL place the state encoding (IDLE/SERVE/PLAY/PAUSE) and the default geometry constants in shared package pong_pkg.
REQ-032 SHALL implement the synchroniser and debouncer as sub-module button_debounce, instantiated once per player.

Verification (DEB_CYCLES=4)
REQ-033 Reset, then hold p1_button=1 for 6 cycles -> exactly one press pulse; state IDLE->SERVE; p1_y=p2_y=208.
REQ-034 In PLAY, three p1_up pulses then frame_tick -> p1_y=184; ten p2_down pulses then frame_tick -> p2_y=208+7*8=264.
REQ-035 With p1_y=8 and count=+2 in PLAY, frame_tick -> p1_y=0; with p2_y=416 and count=-1, frame_tick -> p2_y=416 (clamped).
REQ-036 p1_up coincident with frame_tick -> the tick applies the previous count, the new count=1, and the next tick moves the paddle a further 8.
REQ-037 In PLAY, point_scored and a p2 press in the same cycle -> state=SERVE, server=1; a p1 press is then ignored; a p2 press -> PLAY with serve_start high for exactly 1 cycle.
REQ-038 A 2-cycle button glitch -> no press pulse; rst_n=0 during PAUSE -> state=IDLE and paddles=208 next cycle.
